// File: rtl/ccd_frame_sched.sv
// -----------------------------------------------------------------------------
// ccd_frame_sched
//
// Frame-acquisition scheduler between the CPU configuration/interrupt lines and
// ccd_top. It requests frames from ccd_top with low pulses on ccd_start_n, turns
// each ccd_top read-ready edge into a host interrupt, and returns the host ack
// to ccd_top as a fixed-width cpu_irq pulse. Supports single-shot, N-frame and
// continuous capture with a programmable inter-frame gap and a watchdog on the
// wait for frame data.
//
// Ports
//   clk, rst_n   system clock, synchronous active-low reset
//   arm          rising edge starts a capture sequence (config sampled here)
//   abort        level, forces the scheduler idle while high
//   continuous   1 = capture until abort, 0 = capture n_frames frames
//   n_frames     frames per sequence (0 behaves as 1)
//   gap_cycles   idle cycles between the end of an ack relay and the next start
//   ccd_rd_irq   ccd_top frame-ready (rising edge)
//   host_ack     CPU read-finished (rising edge)
//   ccd_start_n  active-low frame request to ccd_top, START_W cycles wide
//   ccd_cpu_irq  ack relay to ccd_top, ACK_W cycles wide
//   host_irq     frame-ready interrupt to the CPU, held until host_ack
//   busy         sequence in progress
//   done         one-cycle pulse on normal completion
//   err          sticky read-timeout flag
//   frame_cnt    frames completed in the current sequence (saturating)
//
// All outputs are registered and follow the controller state with one cycle of
// latency: an event seen at clock edge N shows on the outputs from edge N+1.
// abort is the exception and forces the outputs idle at the edge it is seen.
// -----------------------------------------------------------------------------
module ccd_frame_sched #(
   parameter int unsigned START_W  = 4,
   parameter int unsigned ACK_W    = 3,
   parameter int unsigned GAP_BITS = 24,
   parameter int unsigned TIMEOUT  = 24'd1000000,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                arm,
   input  logic                abort,
   input  logic                continuous,
   input  logic [CNT_BITS-1:0] n_frames,
   input  logic [GAP_BITS-1:0] gap_cycles,
   input  logic                ccd_rd_irq,
   input  logic                host_ack,
   output logic                ccd_start_n,
   output logic                ccd_cpu_irq,
   output logic                host_irq,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [CNT_BITS-1:0] frame_cnt
);

   localparam int unsigned PW_MAX  = (START_W > ACK_W) ? START_W : ACK_W;
   localparam int unsigned PW_BITS = (PW_MAX > 1) ? $clog2(PW_MAX) : 1;
   localparam int unsigned TO_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_RD,
      S_WAIT_ACK,
      S_RELAY,
      S_GAP,
      S_ERR
   } state_t;

   state_t              state_q,    state_d;
   logic                arm_prev_q, arm_prev_d;
   logic                arm_ok_q,   arm_ok_d;
   logic                rd_prev_q,  rd_prev_d;
   logic                ack_prev_q, ack_prev_d;
   logic                cont_q,     cont_d;
   logic [CNT_BITS-1:0] nfr_q,      nfr_d;
   logic [GAP_BITS-1:0] gap_q,      gap_d;
   logic [PW_BITS-1:0]  pcnt_q,     pcnt_d;
   logic [GAP_BITS-1:0] gcnt_q,     gcnt_d;
   logic [TO_BITS-1:0]  tcnt_q,     tcnt_d;
   logic [CNT_BITS-1:0] fcnt_q,     fcnt_d;
   logic                err_st_q,   err_st_d;
   logic                fin_q,      fin_d;
   logic                start_n_q,  start_n_d;
   logic                cpu_irq_q,  cpu_irq_d;
   logic                host_irq_q, host_irq_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                err_q,      err_d;
   logic [CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;

   logic                arm_rise, rd_rise, ack_rise;
   logic [CNT_BITS-1:0] target;

   // arm_ok_q only becomes set once arm has been seen low after reset, so an
   // arm level held high through reset is not mistaken for a fresh rise.
   assign arm_rise = arm & ~arm_prev_q & arm_ok_q;
   assign rd_rise  = ccd_rd_irq & ~rd_prev_q;
   assign ack_rise = host_ack & ~ack_prev_q;
   assign target   = (nfr_q == '0) ? CNT_BITS'(1) : nfr_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      arm_prev_d = arm;
      arm_ok_d   = arm_ok_q | ~arm;
      rd_prev_d  = ccd_rd_irq;
      ack_prev_d = host_ack;
      cont_d     = cont_q;
      nfr_d      = nfr_q;
      gap_d      = gap_q;
      pcnt_d     = pcnt_q;
      gcnt_d     = gcnt_q;
      tcnt_d     = tcnt_q;
      fcnt_d     = fcnt_q;
      err_st_d   = err_st_q;
      fin_d      = 1'b0;

      // Outputs reflect the state held before this edge.
      start_n_d   = (state_q != S_START);
      cpu_irq_d   = (state_q == S_RELAY);
      host_irq_d  = (state_q == S_WAIT_ACK);
      busy_d      = !(state_q inside {S_IDLE, S_ERR});
      done_d      = fin_q;
      err_d       = err_st_q;
      frame_cnt_d = fcnt_q;

      if (abort) begin
         // abort beats every event, including arm, and leaves err and the
         // frame count untouched.
         state_d    = S_IDLE;
         start_n_d  = 1'b1;
         cpu_irq_d  = 1'b0;
         host_irq_d = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_ERR: begin
               if (arm_rise) begin
                  cont_d   = continuous;
                  nfr_d    = n_frames;
                  gap_d    = gap_cycles;
                  fcnt_d   = '0;
                  err_st_d = 1'b0;
                  pcnt_d   = '0;
                  state_d  = S_START;
               end
            end
            S_START: begin
               if (pcnt_q == PW_BITS'(START_W - 1)) begin
                  tcnt_d  = '0;
                  state_d = S_WAIT_RD;
               end else begin
                  pcnt_d = pcnt_q + PW_BITS'(1);
               end
            end
            S_WAIT_RD: begin
               // A frame-ready edge in the expiry cycle still counts.
               if (rd_rise) begin
                  fcnt_d  = (fcnt_q == '1) ? fcnt_q : fcnt_q + CNT_BITS'(1);
                  state_d = S_WAIT_ACK;
               end else if (tcnt_q == TO_BITS'(TIMEOUT - 1)) begin
                  err_st_d = 1'b1;
                  state_d  = S_ERR;
               end else begin
                  tcnt_d = tcnt_q + TO_BITS'(1);
               end
            end
            S_WAIT_ACK: begin
               if (ack_rise) begin
                  pcnt_d  = '0;
                  state_d = S_RELAY;
               end
            end
            S_RELAY: begin
               if (pcnt_q == PW_BITS'(ACK_W - 1)) begin
                  if (!cont_q && (fcnt_q == target)) begin
                     fin_d   = 1'b1;
                     state_d = S_IDLE;
                  end else if (gap_q == '0) begin
                     pcnt_d  = '0;
                     state_d = S_START;
                  end else begin
                     gcnt_d  = '0;
                     state_d = S_GAP;
                  end
               end else begin
                  pcnt_d = pcnt_q + PW_BITS'(1);
               end
            end
            S_GAP: begin
               if (gcnt_q == gap_q - GAP_BITS'(1)) begin
                  pcnt_d  = '0;
                  state_d = S_START;
               end else begin
                  gcnt_d = gcnt_q + GAP_BITS'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= S_IDLE;
         arm_prev_q  <= 1'b0;
         arm_ok_q    <= 1'b0;
         rd_prev_q   <= 1'b0;
         ack_prev_q  <= 1'b0;
         cont_q      <= 1'b0;
         nfr_q       <= '0;
         gap_q       <= '0;
         pcnt_q      <= '0;
         gcnt_q      <= '0;
         tcnt_q      <= '0;
         fcnt_q      <= '0;
         err_st_q    <= 1'b0;
         fin_q       <= 1'b0;
         start_n_q   <= 1'b1;
         cpu_irq_q   <= 1'b0;
         host_irq_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         arm_prev_q  <= arm_prev_d;
         arm_ok_q    <= arm_ok_d;
         rd_prev_q   <= rd_prev_d;
         ack_prev_q  <= ack_prev_d;
         cont_q      <= cont_d;
         nfr_q       <= nfr_d;
         gap_q       <= gap_d;
         pcnt_q      <= pcnt_d;
         gcnt_q      <= gcnt_d;
         tcnt_q      <= tcnt_d;
         fcnt_q      <= fcnt_d;
         err_st_q    <= err_st_d;
         fin_q       <= fin_d;
         start_n_q   <= start_n_d;
         cpu_irq_q   <= cpu_irq_d;
         host_irq_q  <= host_irq_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign ccd_start_n = start_n_q;
   assign ccd_cpu_irq = cpu_irq_q;
   assign host_irq    = host_irq_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ccd_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_ccd_frame_sched
//
// Bench for ccd_frame_sched. A phase/deadline model of the scheduler predicts
// every output on every clock; directed scenarios pin the model with literal
// cycle-level expectations, then a randomized run exercises the rest.
// -----------------------------------------------------------------------------
module tb_ccd_frame_sched;

   localparam int unsigned START_W  = 4;
   localparam int unsigned ACK_W    = 3;
   localparam int unsigned GAP_BITS = 8;
   localparam int unsigned TIMEOUT  = 100;
   localparam int unsigned CNT_BITS = 3;
   localparam int          CNT_MAX  = (1 << CNT_BITS) - 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                arm;
   logic                abort;
   logic                continuous;
   logic [CNT_BITS-1:0] n_frames;
   logic [GAP_BITS-1:0] gap_cycles;
   logic                ccd_rd_irq;
   logic                host_ack;
   logic                ccd_start_n;
   logic                ccd_cpu_irq;
   logic                host_irq;
   logic                busy;
   logic                done;
   logic                err;
   logic [CNT_BITS-1:0] frame_cnt;

   int tests = 0;
   int fails = 0;

   ccd_frame_sched #(
      .START_W  (START_W),
      .ACK_W    (ACK_W),
      .GAP_BITS (GAP_BITS),
      .TIMEOUT  (TIMEOUT),
      .CNT_BITS (CNT_BITS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arm         (arm),
      .abort       (abort),
      .continuous  (continuous),
      .n_frames    (n_frames),
      .gap_cycles  (gap_cycles),
      .ccd_rd_irq  (ccd_rd_irq),
      .host_ack    (host_ack),
      .ccd_start_n (ccd_start_n),
      .ccd_cpu_irq (ccd_cpu_irq),
      .host_irq    (host_irq),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: the sequence is a list of phases, each with a fixed
   // length measured from the edge it begins at. Outputs after an edge show
   // the phase that was in force before that edge.
   // ---------------------------------------------------------------------------
   typedef enum {P_OFF, P_FAULT, P_STARTING, P_WAITFRAME, P_WAITHOST, P_ACKING, P_GAPPING} phase_t;

   typedef struct packed {
      logic                start_n;
      logic                cpu_irq;
      logic                host_irq;
      logic                busy;
      logic                done;
      logic                err;
      logic [CNT_BITS-1:0] cnt;
   } obs_t;

   phase_t ph = P_OFF;
   longint k = 0;
   longint ph_end = 0;
   bit     m_cont, m_err, m_done_pend, p_arm, p_rd, p_ack, arm_ok;
   int     m_target, m_gap, m_frames;
   obs_t   exp_o;

   function automatic void model_step();
      bit arm_r, rd_r, ack_r;
      k++;
      if (!rst_n) begin
         ph = P_OFF; m_frames = 0; m_err = 0; m_done_pend = 0;
         p_arm = 0; p_rd = 0; p_ack = 0; arm_ok = 0;
         exp_o.start_n = 1'b1; exp_o.cpu_irq = 1'b0; exp_o.host_irq = 1'b0;
         exp_o.busy = 1'b0; exp_o.done = 1'b0; exp_o.err = 1'b0; exp_o.cnt = '0;
         return;
      end
      arm_r = arm && !p_arm && arm_ok;
      rd_r  = ccd_rd_irq && !p_rd;
      ack_r = host_ack && !p_ack;
      p_arm = arm; p_rd = ccd_rd_irq; p_ack = host_ack;
      if (!arm) arm_ok = 1;

      exp_o.start_n  = (ph != P_STARTING);
      exp_o.cpu_irq  = (ph == P_ACKING);
      exp_o.host_irq = (ph == P_WAITHOST);
      exp_o.busy     = !(ph == P_OFF || ph == P_FAULT);
      exp_o.done     = m_done_pend;
      exp_o.err      = m_err;
      exp_o.cnt      = CNT_BITS'(m_frames);
      m_done_pend    = 0;

      if (abort) begin
         ph = P_OFF;
         exp_o.start_n = 1'b1; exp_o.cpu_irq = 1'b0; exp_o.host_irq = 1'b0;
         exp_o.busy = 1'b0; exp_o.done = 1'b0;
         return;
      end

      case (ph)
         P_OFF, P_FAULT: if (arm_r) begin
            m_cont   = continuous;
            m_target = (n_frames == 0) ? 1 : int'(n_frames);
            m_gap    = int'(gap_cycles);
            m_frames = 0;
            m_err    = 0;
            ph = P_STARTING; ph_end = k + START_W;
         end
         P_STARTING: if (k == ph_end) begin
            ph = P_WAITFRAME; ph_end = k + TIMEOUT;
         end
         P_WAITFRAME: begin
            if (rd_r) begin
               if (m_frames < CNT_MAX) m_frames++;
               ph = P_WAITHOST;
            end else if (k == ph_end) begin
               m_err = 1;
               ph = P_FAULT;
            end
         end
         P_WAITHOST: if (ack_r) begin
            ph = P_ACKING; ph_end = k + ACK_W;
         end
         P_ACKING: if (k == ph_end) begin
            if (!m_cont && m_frames == m_target) begin
               ph = P_OFF; m_done_pend = 1;
            end else if (m_gap == 0) begin
               ph = P_STARTING; ph_end = k + START_W;
            end else begin
               ph = P_GAPPING; ph_end = k + m_gap;
            end
         end
         P_GAPPING: if (k == ph_end) begin
            ph = P_STARTING; ph_end = k + START_W;
         end
         default: ph = P_OFF;
      endcase
   endfunction

   // Compare process: model and DUT both advance on the edge, outputs are
   // compared 1 time unit later.
   always @(posedge clk) begin
      obs_t got;
      model_step();
      #1;
      got = {ccd_start_n, ccd_cpu_irq, host_irq, busy, done, err, frame_cnt};
      tests++;
      if (got !== exp_o) begin
         fails++;
         $display("FAIL cycle_%0d outputs: got sn=%b ci=%b hi=%b bz=%b dn=%b er=%b cnt=%0d, expected sn=%b ci=%b hi=%b bz=%b dn=%b er=%b cnt=%0d",
                  k, got.start_n, got.cpu_irq, got.host_irq, got.busy, got.done, got.err, got.cnt,
                  exp_o.start_n, exp_o.cpu_irq, exp_o.host_irq, exp_o.busy, exp_o.done, exp_o.err, exp_o.cnt);
      end
   end

   // Event counters for directed scenarios.
   int   starts_seen = 0;
   int   dones_seen  = 0;
   logic prev_sn     = 1'b1;

   always @(posedge clk) begin
      #2;
      if (prev_sn && !ccd_start_n) starts_seen++;
      if (done === 1'b1) dones_seen++;
      prev_sn = ccd_start_n;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // sel: 0 = ccd_start_n, 1 = host_irq, 2 = ccd_cpu_irq
   task automatic wait_for(input string name, input int sel, input logic want, input int max_cyc);
      bit seen = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         case (sel)
            0:       seen = (ccd_start_n === want);
            1:       seen = (host_irq === want);
            default: seen = (ccd_cpu_irq === want);
         endcase
      end
      check({name, "_reached"}, 32'(seen), 32'd1);
   endtask

   // One frame handshake once the start pulse has been issued.
   task automatic do_frame(input string name);
      wait_for({name, "_st_lo"}, 0, 1'b0, 40);
      wait_for({name, "_st_hi"}, 0, 1'b1, 10);
      ccd_rd_irq = 1'b1;
      wait_for({name, "_hirq"}, 1, 1'b1, 5);
      ccd_rd_irq = 1'b0;
      host_ack   = 1'b1;
      wait_for({name, "_cpu_hi"}, 2, 1'b1, 5);
      host_ack   = 1'b0;
      wait_for({name, "_cpu_lo"}, 2, 1'b0, 10);
   endtask

   initial begin
      int d;
      int s0;
      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
      n_frames = '0; gap_cycles = '0; ccd_rd_irq = 1'b0; host_ack = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(1);
      check("rst_start_n", 32'(ccd_start_n), 1);
      check("rst_busy",    32'(busy), 0);
      check("rst_err",     32'(err), 0);
      check("rst_cnt",     32'(frame_cnt), 0);

      // ---- single shot -------------------------------------------------------
      n_frames = CNT_BITS'(1); continuous = 1'b0; gap_cycles = '0;
      arm = 1'b1;
      step(1);                                       // after edge N
      check("ss_sn_N",  32'(ccd_start_n), 1);
      step(1);
      check("ss_sn_N1", 32'(ccd_start_n), 0);
      step(3);
      check("ss_sn_N4", 32'(ccd_start_n), 0);
      step(1);
      check("ss_sn_N5", 32'(ccd_start_n), 1);
      host_ack = 1'b1;                               // stray ack in WAIT_RD
      step(2);
      host_ack = 1'b0;
      step(2);
      check("stray_ack_cpu", 32'(ccd_cpu_irq), 0);
      check("stray_ack_cnt", 32'(frame_cnt), 0);
      step(30);
      ccd_rd_irq = 1'b1;
      step(1);                                       // after edge R
      check("ss_hirq_R", 32'(host_irq), 0);
      step(1);
      check("ss_hirq_R1", 32'(host_irq), 1);
      check("ss_cnt_R1",  32'(frame_cnt), 1);
      ccd_rd_irq = 1'b0;
      step(3);
      host_ack = 1'b1;
      step(1);                                       // after edge A
      check("ss_cpu_A", 32'(ccd_cpu_irq), 0);
      step(1);
      check("ss_cpu_A1",  32'(ccd_cpu_irq), 1);
      check("ss_hirq_A1", 32'(host_irq), 0);
      step(2);
      check("ss_cpu_A3",  32'(ccd_cpu_irq), 1);
      check("ss_busy_A3", 32'(busy), 1);
      step(1);
      check("ss_cpu_A4",  32'(ccd_cpu_irq), 0);
      check("ss_done_A4", 32'(done), 1);
      check("ss_busy_A4", 32'(busy), 0);
      step(1);
      check("ss_done_A5", 32'(done), 0);
      host_ack = 1'b0; arm = 1'b0;
      step(3);

      // ---- three frames, gap 5, with stray rd_irq and a second arm -----------
      n_frames = CNT_BITS'(3); gap_cycles = GAP_BITS'(5);
      starts_seen = 0; dones_seen = 0;
      arm = 1'b1;
      step(1);
      ccd_rd_irq = 1'b1;                             // rises during START
      step(1);
      ccd_rd_irq = 1'b0;
      wait_for("f3_st_hi0", 0, 1'b1, 10);
      step(2);
      check("stray_rd_cnt",  32'(frame_cnt), 0);
      check("stray_rd_hirq", 32'(host_irq), 0);
      arm = 1'b0; step(1); arm = 1'b1; step(2);      // arm again while busy
      check("rearm_busy_sn", 32'(ccd_start_n), 1);
      for (int f = 0; f < 3; f++) begin
         ccd_rd_irq = 1'b1;
         wait_for("f3_hirq", 1, 1'b1, 5);
         ccd_rd_irq = 1'b0;
         host_ack   = 1'b1;
         wait_for("f3_cpu_hi", 2, 1'b1, 5);
         host_ack   = 1'b0;
         wait_for("f3_cpu_lo", 2, 1'b0, 10);
         if (f < 2) begin
            d = 0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               d++;
               if (!ccd_start_n) break;
            end
            check("f3_gap", 32'(d), 5);
            wait_for("f3_st_hi", 0, 1'b1, 10);
         end
      end
      step(20);
      check("f3_cnt",    32'(frame_cnt), 3);
      check("f3_starts", 32'(starts_seen), 3);
      check("f3_dones",  32'(dones_seen), 1);
      arm = 1'b0;
      step(2);

      // ---- timeout then re-arm ----------------------------------------------
      n_frames = CNT_BITS'(1); gap_cycles = '0;
      arm = 1'b1;
      step(105);                                     // after edge N+104
      check("to_err_early", 32'(err), 0);
      step(1);
      check("to_err",  32'(err), 1);
      check("to_busy", 32'(busy), 0);
      arm = 1'b0; step(1); arm = 1'b1;
      step(2);
      check("to_rearm_err", 32'(err), 0);
      check("to_rearm_sn",  32'(ccd_start_n), 0);
      abort = 1'b1; step(1); abort = 1'b0; arm = 1'b0;
      step(2);

      // ---- continuous, abort in WAIT_ACK --------------------------------------
      continuous = 1'b1; n_frames = '0; gap_cycles = '0;
      starts_seen = 0; dones_seen = 0;
      arm = 1'b1;
      do_frame("c0");
      do_frame("c1");
      wait_for("c2_st_lo", 0, 1'b0, 40);
      wait_for("c2_st_hi", 0, 1'b1, 10);
      ccd_rd_irq = 1'b1;
      wait_for("c2_hirq", 1, 1'b1, 5);
      ccd_rd_irq = 1'b0;
      abort = 1'b1;
      step(1);
      check("ab_hirq", 32'(host_irq), 0);
      check("ab_sn",   32'(ccd_start_n), 1);
      check("ab_busy", 32'(busy), 0);
      check("ab_cnt",  32'(frame_cnt), 3);
      abort = 1'b0;
      step(1);
      s0 = starts_seen;
      host_ack = 1'b1; step(2); host_ack = 1'b0;
      step(30);
      check("ab_starts", 32'(starts_seen), 32'(s0));
      check("ab_nstart", 32'(s0), 3);
      check("ab_dones",  32'(dones_seen), 0);
      check("ab_cnt2",   32'(frame_cnt), 3);
      arm = 1'b0; continuous = 1'b0;
      step(2);

      // ---- reset mid-START, arm held through reset ----------------------------
      arm = 1'b1;
      step(3);
      check("rs_pre_sn", 32'(ccd_start_n), 0);
      rst_n = 1'b0;
      step(1);
      check("rs_sn",   32'(ccd_start_n), 1);
      check("rs_busy", 32'(busy), 0);
      check("rs_cnt",  32'(frame_cnt), 0);
      rst_n = 1'b1;
      starts_seen = 0;
      step(15);
      check("rs_held_starts", 32'(starts_seen), 0);
      check("rs_held_busy",   32'(busy), 0);
      arm = 1'b0; step(2); arm = 1'b1;
      step(3);
      check("rs_fresh_sn", 32'(ccd_start_n), 0);
      abort = 1'b1; step(1); abort = 1'b0; arm = 1'b0;
      step(2);

      // ---- randomized run -----------------------------------------------------
      for (int i = 0; i < 7000; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 1499) != 0);
         if ($urandom_range(0, 799) == 0) abort = 1'b1;
         else if (abort && $urandom_range(0, 2) == 0) abort = 1'b0;
         if ($urandom_range(0, 39) == 0) arm = ~arm;
         if ($urandom_range(0, 24) == 0) ccd_rd_irq = ~ccd_rd_irq;
         if ($urandom_range(0, 7) == 0) host_ack = ~host_ack;
         if ($urandom_range(0, 29) == 0) begin
            continuous = ($urandom_range(0, 2) == 0);
            n_frames   = CNT_BITS'($urandom_range(0, CNT_MAX));
            gap_cycles = GAP_BITS'($urandom_range(0, 6));
         end
      end
      rst_n = 1'b1; abort = 1'b0;
      step(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
